vga_fb_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between the VGA scan-out read path and a pixel writer.

---
 rtl/vga_fb_arbiter.sv | 128 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display reads take the RAM port every requested cycle,
// writer pixels queue in a small FIFO and drain on read-free cycles. Stall counter: VGA_FB_STALL_CNT_EN.
module vga_fb_arbiter #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Rd_Req,
    input  logic [ADDR_WIDTH-1:0] i_Rd_Addr,
    output logic                  o_Rd_Valid,
    output logic [DATA_WIDTH-1:0] o_Rd_Data,
    input  logic                  i_Wr_Valid,
    output logic                  o_Wr_Ready,
    input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
    input  logic [DATA_WIDTH-1:0] i_Wr_Data,
    output logic                  o_Wr_Busy,
    output logic [ADDR_WIDTH-1:0] o_Ram_Addr,
    output logic                  o_Ram_Wr_En,
    output logic [DATA_WIDTH-1:0] o_Ram_Wr_Data,
    input  logic [DATA_WIDTH-1:0] i_Ram_Rd_Data
`ifdef VGA_FB_STALL_CNT_EN
    ,
    input  logic                  i_Stall_Clr,
    output logic [15:0]           o_Stall_Count
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    // [0] request accepted, [1] address on RAM, [2] RAM data available
    logic [2:0]            vld_pipe;

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, count_next, pend;
    logic                  push, pop;

    assign push = i_Wr_Valid && o_Wr_Ready;
    assign pop  = (state == S_WRITE);
    // An entry already claimed by the current write cycle must not schedule another pop.
    assign pend = pop ? CNT_W'(1) : '0;

    always_comb begin
        state_next = S_IDLE;
        if (i_Rd_Req)
            state_next = S_READ;
        else if (count > pend)
            state_next = S_WRITE;
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_Wr_Addr;
            fifo_data[wr_ptr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= S_IDLE;
            rd_addr_q     <= '0;
            vld_pipe      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_Wr_Ready    <= 1'b0;
            o_Wr_Busy     <= 1'b0;
            o_Ram_Addr    <= '0;
            o_Ram_Wr_En   <= 1'b0;
            o_Ram_Wr_Data <= '0;
            o_Rd_Valid    <= 1'b0;
            o_Rd_Data     <= '0;
        end else begin
            state     <= state_next;
            rd_addr_q <= i_Rd_Addr;
            vld_pipe  <= {vld_pipe[1:0], state_next == S_READ};

            o_Ram_Wr_En <= 1'b0;
            case (state)
                S_READ:  o_Ram_Addr <= rd_addr_q;
                S_WRITE: begin
                    o_Ram_Addr    <= fifo_addr[rd_ptr];
                    o_Ram_Wr_Data <= fifo_data[rd_ptr];
                    o_Ram_Wr_En   <= 1'b1;
                end
                default: ;
            endcase

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_next;
            o_Wr_Ready <= (count_next != FULL_CNT);
            o_Wr_Busy  <= (count_next != '0);

            o_Rd_Valid <= vld_pipe[2];
            if (vld_pipe[2]) o_Rd_Data <= i_Ram_Rd_Data;
        end
    end

`ifdef VGA_FB_STALL_CNT_EN
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            o_Stall_Count <= '0;
        else if (i_Stall_Clr)
            o_Stall_Count <= '0;
        else if (i_Wr_Valid && !o_Wr_Ready && (o_Stall_Count != 16'hFFFF))
            o_Stall_Count <= o_Stall_Count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: cycle table for the basic read/write flow,
// then hand-written sequences for latency, priority/full, interleave, reset and stall counting.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [18:0] rd_addr = '0;
    logic        rd_valid;
    logic [8:0]  rd_data;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [18:0] wr_addr = '0;
    logic [8:0]  wr_data = '0;
    logic        wr_busy;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [8:0]  ram_wd;
    logic [8:0]  ram_q;
    logic        preload = 1'b0;
`ifdef VGA_FB_STALL_CNT_EN
    logic        stall_clr = 1'b0;
    logic [15:0] stall_count;
`endif

    int errors = 0;
    int checks = 0;

    always #20 clk = ~clk;

    vga_fb_arbiter dut (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_Rd_Req(rd_req), .i_Rd_Addr(rd_addr),
        .o_Rd_Valid(rd_valid), .o_Rd_Data(rd_data),
        .i_Wr_Valid(wr_valid), .o_Wr_Ready(wr_ready),
        .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data), .o_Wr_Busy(wr_busy),
        .o_Ram_Addr(ram_addr), .o_Ram_Wr_En(ram_we), .o_Ram_Wr_Data(ram_wd),
        .i_Ram_Rd_Data(ram_q)
`ifdef VGA_FB_STALL_CNT_EN
        , .i_Stall_Clr(stall_clr), .o_Stall_Count(stall_count)
`endif
    );

    // Single-port synchronous RAM model, 1024 words are enough for these tests.
    logic [8:0] mem [1024];
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 9'(k);
        end else if (ram_we) begin
            mem[ram_addr[9:0]] <= ram_wd;
        end
        ram_q <= mem[ram_addr[9:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rd;   logic [18:0] ra;
        logic        wv;   logic [18:0] wa;  logic [8:0] wd;
        logic        e_rv; logic [8:0]  e_rd; logic e_rdy; logic e_busy;
        logic        e_we; logic [18:0] e_ra; logic [8:0] e_wd;
    } vec_t;
    vec_t tbl [8];

    int pushed, n, we_seen, pulses;
    logic [18:0] got_addr [8];
    logic [8:0]  got_data [8];
    int          got_cyc  [8];
    logic        req_hist [48];
    logic [18:0] req_addr [48];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // row c inputs are sampled at the next edge; expected outputs are those right after it
        tbl[0] = '{1'b1, 19'd5,  1'b0, 19'd0,  9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 19'd0,  9'h000};
        tbl[1] = '{1'b1, 19'd6,  1'b1, 19'd20, 9'h1AA, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 19'd5,  9'h000};
        tbl[2] = '{1'b0, 19'd0,  1'b0, 19'd0,  9'h000, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 19'd6,  9'h000};
        tbl[3] = '{1'b1, 19'd20, 1'b0, 19'd0,  9'h000, 1'b1, 9'h005, 1'b1, 1'b0, 1'b1, 19'd20, 9'h1AA};
        tbl[4] = '{1'b0, 19'd0,  1'b0, 19'd0,  9'h000, 1'b1, 9'h006, 1'b1, 1'b0, 1'b0, 19'd20, 9'h000};
        tbl[5] = '{1'b0, 19'd0,  1'b0, 19'd0,  9'h000, 1'b0, 9'h006, 1'b1, 1'b0, 1'b0, 19'd20, 9'h000};
        tbl[6] = '{1'b0, 19'd0,  1'b0, 19'd0,  9'h000, 1'b1, 9'h1AA, 1'b1, 1'b0, 1'b0, 19'd20, 9'h000};
        tbl[7] = '{1'b0, 19'd0,  1'b0, 19'd0,  9'h000, 1'b0, 9'h1AA, 1'b1, 1'b0, 1'b0, 19'd20, 9'h000};

        // reset with random inputs
        preload = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rd_req   = 1'($urandom);
            rd_addr  = 19'($urandom);
            wr_valid = 1'($urandom);
            wr_addr  = 19'($urandom);
            wr_data  = 9'($urandom);
            step();
            preload = 1'b0;
        end
        chk("rst_flags", {31'd0, rd_valid | wr_ready | wr_busy | ram_we}, 0);
        chk("rst_ram_addr", {13'd0, ram_addr}, 0);
        chk("rst_rd_data", {23'd0, rd_data}, 0);
        chk("rst_ram_wd", {23'd0, ram_wd}, 0);
`ifdef VGA_FB_STALL_CNT_EN
        chk("rst_stall", {16'd0, stall_count}, 0);
`endif
        rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rst_n = 1'b1;
        step();
        chk("rel_ready", {31'd0, wr_ready}, 1);
        chk("rel_busy", {31'd0, wr_busy}, 0);

        // cycle table
        for (int r = 0; r < 8; r++) begin
            rd_req = tbl[r].rd; rd_addr = tbl[r].ra;
            wr_valid = tbl[r].wv; wr_addr = tbl[r].wa; wr_data = tbl[r].wd;
            step();
            chk($sformatf("vec%0d_rd_valid", r), {31'd0, rd_valid}, {31'd0, tbl[r].e_rv});
            chk($sformatf("vec%0d_rd_data", r), {23'd0, rd_data}, {23'd0, tbl[r].e_rd});
            chk($sformatf("vec%0d_ready", r), {31'd0, wr_ready}, {31'd0, tbl[r].e_rdy});
            chk($sformatf("vec%0d_busy", r), {31'd0, wr_busy}, {31'd0, tbl[r].e_busy});
            chk($sformatf("vec%0d_wr_en", r), {31'd0, ram_we}, {31'd0, tbl[r].e_we});
            chk($sformatf("vec%0d_ram_addr", r), {13'd0, ram_addr}, {13'd0, tbl[r].e_ra});
            if (tbl[r].e_we)
                chk($sformatf("vec%0d_ram_wd", r), {23'd0, ram_wd}, {23'd0, tbl[r].e_wd});
        end
        rd_req = 1'b0; wr_valid = 1'b0;

        // read latency over a 640-pixel line
        preload = 1'b1; step(); preload = 1'b0; step();
        for (int c = 0; c < 644; c++) begin
            rd_req = (c < 640);
            rd_addr = 19'(c);
            step();
            chk($sformatf("line_valid_c%0d", c), {31'd0, rd_valid}, {31'd0, c >= 3 && c < 643});
            if (c >= 3 && c < 643)
                chk($sformatf("line_data_c%0d", c), {23'd0, rd_data}, 32'((c - 3) % 512));
        end
        chk("line_hold", {23'd0, rd_data}, 32'(639 % 512));
        rd_req = 1'b0;
        repeat (3) step();

        // priority and full FIFO
        rd_req = 1'b1; rd_addr = 19'd50; wr_valid = 1'b1; pushed = 0; we_seen = 0;
        for (int c = 0; c < 10; c++) begin
            wr_addr = 19'(200 + pushed); wr_data = 9'(9'h100 + pushed);
            if (wr_ready) pushed++;
            step();
            if (ram_we) we_seen++;
        end
        chk("full_accepted", 32'(pushed), 4);
        chk("full_ready", {31'd0, wr_ready}, 0);
        chk("full_no_write", 32'(we_seen), 0);
        chk("full_busy", {31'd0, wr_busy}, 1);
        rd_req = 1'b0; n = 0;
        for (int c = 0; c < 40; c++) begin
            wr_valid = (pushed < 6);
            wr_addr = 19'(200 + pushed); wr_data = 9'(9'h100 + pushed);
            if (wr_valid && wr_ready) pushed++;
            step();
            if (ram_we && n < 8) begin
                got_addr[n] = ram_addr; got_data[n] = ram_wd; got_cyc[n] = c; n++;
            end
        end
        wr_valid = 1'b0;
        chk("drain_count", 32'(n), 6);
        if (n >= 4) chk("drain_consecutive", 32'(got_cyc[3] - got_cyc[0]), 3);
        for (int i = 0; i < 6 && i < n; i++) begin
            chk($sformatf("drain%0d_addr", i), {13'd0, got_addr[i]}, 32'(200 + i));
            chk($sformatf("drain%0d_data", i), {23'd0, got_data[i]}, 32'(9'h100 + i));
        end
        chk("drain_mem205", {23'd0, mem[205]}, 32'h105);
        chk("drain_idle_busy", {31'd0, wr_busy}, 0);

        // alternating reads with continuous writes
        preload = 1'b1; step(); preload = 1'b0; step();
        pushed = 0; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            rd_req = (c < 24) && (c % 2 == 0);
            rd_addr = 19'(300 + c);
            req_hist[c] = rd_req; req_addr[c] = rd_addr;
            wr_valid = (pushed < 8);
            wr_addr = 19'(400 + pushed); wr_data = 9'(9'h0C0 + pushed);
            if (wr_valid && wr_ready) pushed++;
            step();
            if (c >= 1 && req_hist[c-1]) begin
                chk($sformatf("il_c%0d_no_wr", c), {31'd0, ram_we}, 0);
                chk($sformatf("il_c%0d_rd_addr", c), {13'd0, ram_addr}, {13'd0, req_addr[c-1]});
            end
            if (c >= 3 && req_hist[c-3]) begin
                chk($sformatf("il_c%0d_valid", c), {31'd0, rd_valid}, 1);
                chk($sformatf("il_c%0d_data", c), {23'd0, rd_data}, 32'((300 + c - 3) % 512));
            end else begin
                chk($sformatf("il_c%0d_valid", c), {31'd0, rd_valid}, 0);
            end
            if (ram_we) begin
                chk($sformatf("il_pulse%0d_addr", pulses), {13'd0, ram_addr}, 32'(400 + pulses));
                pulses++;
            end
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        step();
        chk("il_pulses", 32'(pulses), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("il_mem%0d", 400 + i), {23'd0, mem[400 + i]}, 32'(9'h0C0 + i));

        // reset in the middle of draining
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(500 + i); wr_data = 9'(9'h1F0 + i);
            step();
        end
        wr_valid = 1'b0;
        for (int t = 0; t < 10 && !ram_we; t++) step();
        chk("mid_first_pulse", {31'd0, ram_we}, 1);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        we_seen = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (ram_we) we_seen++;
        end
        chk("mid_no_more_writes", 32'(we_seen), 0);
        chk("mid_busy", {31'd0, wr_busy}, 0);
        chk("mid_ready", {31'd0, wr_ready}, 1);
        chk("mid_mem501", {23'd0, mem[501]}, 32'd501);

`ifdef VGA_FB_STALL_CNT_EN
        rd_req = 1'b1; rd_addr = 19'd0; stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("stall_clr0", {16'd0, stall_count}, 0);
        wr_valid = 1'b1; wr_addr = 19'd600; wr_data = 9'h0;
        for (int t = 0; t < 10 && wr_ready; t++) step();
        chk("stall_full", {31'd0, wr_ready}, 0);
        repeat (10) step();
        chk("stall_ten", {16'd0, stall_count}, 10);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("stall_cleared", {16'd0, stall_count}, 0);
        repeat (70000) step();
        chk("stall_saturate", {16'd0, stall_count}, 32'hFFFF);
        wr_valid = 1'b0; rd_req = 1'b0;
        repeat (8) step();
        chk("stall_drained", {31'd0, wr_busy}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
